// File: rtl/sumador_4_bits.sv
// Registered unsigned adder: ripple-carry chain of ANCHO full-adder cells
// followed by one output register stage with a one-cycle valid strobe.
module sumador_4_bits #(
    parameter int ANCHO = 4
) (
    input  logic             Reloj,
    input  logic             Reset,
    input  logic             Habilitar,
    input  logic [ANCHO-1:0] X,
    input  logic [ANCHO-1:0] Y,
    output logic [ANCHO-1:0] Salida,
    output logic             CarriSalida,
    output logic             Valido
);

    logic [ANCHO:0]   carry_p0;
    logic [ANCHO-1:0] suma_p0;

    logic [ANCHO-1:0] suma_p1;
    logic             carry_p1;
    logic             vld_p1;

    assign carry_p0[0] = 1'b0;

    for (genvar i = 0; i < ANCHO; i++) begin : g_celda
        assign suma_p0[i]    = X[i] ^ Y[i] ^ carry_p0[i];
        assign carry_p0[i+1] = (X[i] & Y[i]) | (carry_p0[i] & (X[i] ^ Y[i]));
    end

    // Stage p0 -> p1: sum and carry hold while disabled; valid pulses per enabled sample.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            suma_p1  <= '0;
            carry_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (Habilitar) begin
            suma_p1  <= suma_p0;
            carry_p1 <= carry_p0[ANCHO];
            vld_p1   <= 1'b1;
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign Salida      = suma_p1;
    assign CarriSalida = carry_p1;
    assign Valido      = vld_p1;

endmodule

// File: tb/tb_sumador_4_bits.sv
// Bench for sumador_4_bits: directed cases, exhaustive sweep with a mid-stream
// reset, then randomized traffic against an arithmetic reference model.
module tb_sumador_4_bits;

    localparam int ANCHO = 4;

    logic             Reloj;
    logic             Reset;
    logic             Habilitar;
    logic [ANCHO-1:0] X;
    logic [ANCHO-1:0] Y;
    logic [ANCHO-1:0] Salida;
    logic             CarriSalida;
    logic             Valido;

    int checks_total;
    int checks_passed;

    int exp_sum;
    int exp_carry;
    int exp_vld;

    sumador_4_bits #(.ANCHO(ANCHO)) dut (
        .Reloj       (Reloj),
        .Reset       (Reset),
        .Habilitar   (Habilitar),
        .X           (X),
        .Y           (Y),
        .Salida      (Salida),
        .CarriSalida (CarriSalida),
        .Valido      (Valido)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic check(input string tag, input int got, input int exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one edge, advance the reference model, compare shortly after the edge.
    task automatic step(input string tag, input bit rst, input bit en, input int a, input int b);
        int total;
        Reset     = rst;
        Habilitar = en;
        X         = a[ANCHO-1:0];
        Y         = b[ANCHO-1:0];
        @(posedge Reloj);
        #1;
        if (rst) begin
            exp_sum   = 0;
            exp_carry = 0;
            exp_vld   = 0;
        end else if (en) begin
            total     = (a % (1 << ANCHO)) + (b % (1 << ANCHO));
            exp_sum   = total % (1 << ANCHO);
            exp_carry = total / (1 << ANCHO);
            exp_vld   = 1;
        end else begin
            exp_vld   = 0;
        end
        check({tag, ".sum"},   int'(Salida),      exp_sum);
        check({tag, ".carry"}, int'(CarriSalida), exp_carry);
        check({tag, ".vld"},   int'(Valido),      exp_vld);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        exp_sum       = 0;
        exp_carry     = 0;
        exp_vld       = 0;
        Reset         = 1'b1;
        Habilitar     = 1'b0;
        X             = '0;
        Y             = '0;

        step("reset", 1, 1, 15, 15);
        step("reset_hold", 1, 0, 3, 3);

        step("3p4", 0, 1, 3, 4);
        step("fp1", 0, 1, 15, 1);
        step("fpf", 0, 1, 15, 15);
        step("9p5", 0, 1, 9, 5);
        for (int k = 0; k < 3; k++) step("hold", 0, 0, 15, 15);
        check("hold_const.sum", int'(Salida), 14);

        // Exhaustive sweep; the (7,9) pair lands on a reset edge and is discarded.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (i == 7 && j == 9) step("sweep_rst", 1, 1, i, j);
                else                  step("sweep", 0, 1, i, j);
            end
        end

        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
